cv32e41s_rvfi_obi_instr_tracker: RTL and testbench
==================================================

# cv32e41s_rvfi_obi_instr_tracker

Pairs instruction-side OBI address phases with their response phases and emits one `rvfi_obi_instr_t` record per completed fetch transaction. It sits between the IF-stage OBI interface and the RVFI instruction-tracking logic. It buffers outstanding requests in order in a small FIFO. It also sequences PMP-blocked fetches, which never reach the bus, into the same in-order record stream.

## Interface
- `DEPTH`, default 2: maximum outstanding transactions (bus-issued plus PMP-blocked); must be ≥1.
- `clk` input 1: clock.
- `rst` input 1: synchronous reset, active-high.
- `obi_req_i` input 1: OBI instruction request.
- `obi_gnt_i` input 1: OBI grant.
- `obi_req_payload_i` input `obi_inst_req_t`: address-phase payload.
- `obi_rvalid_i` input 1: OBI response valid.
- `obi_resp_payload_i` input `inst_resp_t`: response-phase payload.
- `pmp_block_i` input 1: fetch accepted internally but blocked by PMP; payload is on `obi_req_payload_i`.
- `rvfi_obi_valid_o` output 1: record valid, one-cycle pulse.
- `rvfi_obi_o` output `rvfi_obi_instr_t`: completed record.
- `outstanding_o` output `$clog2(DEPTH+1)`: current FIFO occupancy.
- `overflow_err_o` output 1: sticky flag; a push was attempted while full.
- `protocol_err_o` output 1: sticky flag; an illegal response was seen.

## Operation
- **Push events.** A push occurs on `obi_req_i && obi_gnt_i`, or on `pmp_block_i`. Each entry stores {req_payload, blocked bit}.
- **Simultaneous push sources.** `pmp_block_i` together with a bus handshake in the same cycle sets `protocol_err_o`. The bus handshake is pushed and the blocked request is dropped.
- **Full FIFO.** A push while full sets `overflow_err_o` and is dropped. A same-cycle pop does not free space for that push.
- **Bus-entry pop.** When the head is a bus entry, `obi_rvalid_i` pops it. The record is {head.req_payload, obi_resp_payload_i, pmp_err=0}.
- **Blocked-entry pop.** When the head is a blocked entry, it pops autonomously in the first cycle it is at head. The record is {head.req_payload, '0, pmp_err=1}.
- **Illegal `obi_rvalid_i`.** `obi_rvalid_i` is illegal when the FIFO is empty (even if a push occurs the same cycle) or when the head is a blocked entry. Either case sets `protocol_err_o`, and the response is ignored with no pop.
- **Pop and push together.** Both take effect in the same cycle. Occupancy is unchanged.
- **Pointers.** Read and write pointers wrap modulo `DEPTH` (DEPTH need not be a power of two). Occupancy is a separate counter of width `$clog2(DEPTH+1)`.
- **Error flags.** Both error flags clear only on reset.

## Timing
- **Reset values.** `rvfi_obi_valid_o`=0, `rvfi_obi_o`='0, `outstanding_o`=0, and both error flags 0. Pointers are zeroed and all FIFO contents are discarded. A reset mid-transaction drops all pending records, and a later `obi_rvalid_i` is flagged as a protocol error.
- **Output latency.** Outputs are registered. `rvfi_obi_valid_o` rises in cycle N+1 for a pop in cycle N and is high for exactly one cycle per pop.
- **Blocked-entry timing.** A blocked entry pushed into an empty FIFO in cycle N pops in N+1, so its record appears in N+2.
- **Throughput.** One record per cycle maximum. Back-to-back `obi_rvalid_i` produces consecutive valid pulses.
- **`outstanding_o`.** Reflects the registered occupancy, updated the cycle after push or pop.
- **No backpressure.** The block is a monitor and never stalls the bus.

## Structure
- `cv32e41s_rvfi_pkg` holds:
  - the entry struct `rvfi_obi_fifo_entry_t` {obi_inst_req_t req_payload; logic blocked};
  - `rvfi_obi_instr_t`, which already exists in that package.
- The sub-module `cv32e41s_rvfi_obi_fifo` is parameterized on `DEPTH` and the entry type. It provides push, pop, full, empty, head and count.
- The top level holds the push/pop decode, the record register and the error flags.

## Test plan
- **Single fetch.** Handshake at addr 0x80 in cycle 1, rvalid with rdata 0x00000013 in cycle 3 → valid pulse in cycle 4 with addr 0x80, rdata 0x13, pmp_err=0; `outstanding_o` goes 1 then 0.
- **Pipelined fetches.** DEPTH=2; handshakes at 0x100 and 0x104 in cycles 1–2, then rvalid in cycles 3–4 → records 0x100 and 0x104 in cycles 4–5, in order.
- **Full with simultaneous push and pop.** FIFO full; rvalid plus a new handshake at 0x108 in the same cycle → `overflow_err_o`=1, 0x108 dropped, `outstanding_o`=1.
- **Mixed PMP-blocked fetch.** Bus entry 0x200, then `pmp_block_i` at 0x204 → the 0x200 record is followed the next cycle by the 0x204 record with pmp_err=1 and resp='0.
- **Illegal response.** rvalid with an empty FIFO → `protocol_err_o`=1, no valid pulse; rvalid with a blocked entry at head → error set and the blocked entry still retires.
- **Reset mid-operation.** Assert `rst` with 2 outstanding → all outputs 0 next cycle; a subsequent rvalid sets `protocol_err_o`.

Source files
------------

// File: rtl/cv32e41s_rvfi_pkg.sv
// Shared types for RVFI instruction-side OBI tracking.
package cv32e41s_rvfi_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
      logic        dbg;
      logic [1:0]  memtype;
   } obi_inst_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } inst_resp_t;

   typedef struct packed {
      obi_inst_req_t req_payload;
      inst_resp_t    resp_payload;
      logic          pmp_err;
   } rvfi_obi_instr_t;

   typedef struct packed {
      obi_inst_req_t req_payload;
      logic          blocked;
   } rvfi_obi_fifo_entry_t;

   // Blocked fetches never saw the bus, so their response half is zero.
   function automatic rvfi_obi_instr_t build_record(input rvfi_obi_fifo_entry_t entry,
                                                    input inst_resp_t           resp);
      rvfi_obi_instr_t rec;
      rec.req_payload  = entry.req_payload;
      rec.resp_payload = entry.blocked ? '0 : resp;
      rec.pmp_err      = entry.blocked;
      return rec;
   endfunction

endpackage

// File: rtl/cv32e41s_rvfi_obi_fifo.sv
// In-order FIFO of outstanding fetch entries; pointers wrap modulo DEPTH.
module cv32e41s_rvfi_obi_fifo
   import cv32e41s_rvfi_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type ENTRY_T = rvfi_obi_fifo_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  ENTRY_T                       i_data,
   input  logic                         i_pop,
   output logic                         o_full,
   output logic                         o_empty,
   output ENTRY_T                       o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   ENTRY_T             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Pointer and occupancy bookkeeping; callers guarantee no push when full and no pop when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         if (i_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an empty count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/cv32e41s_rvfi_obi_instr_tracker.sv
// Pairs instruction OBI address and response phases (plus PMP-blocked fetches)
// into an in-order stream of RVFI fetch records.
module cv32e41s_rvfi_obi_instr_tracker
   import cv32e41s_rvfi_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         obi_req_i,
   input  logic                         obi_gnt_i,
   input  obi_inst_req_t                obi_req_payload_i,
   input  logic                         obi_rvalid_i,
   input  inst_resp_t                   obi_resp_payload_i,
   input  logic                         pmp_block_i,
   output logic                         rvfi_obi_valid_o,
   output rvfi_obi_instr_t              rvfi_obi_o,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
   output logic                         overflow_err_o,
   output logic                         protocol_err_o
);

   logic                  w_bus_hs;
   logic                  w_push_req;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_overflow;
   logic                  w_protocol;
   rvfi_obi_fifo_entry_t  w_push_entry;
   rvfi_obi_fifo_entry_t  w_head;

   logic                  r_valid;
   rvfi_obi_instr_t       r_rec;
   logic                  r_overflow;
   logic                  r_protocol;

   // Push/pop decode; a bus handshake wins over a concurrent PMP block, and a pop never frees room for a same-cycle push.
   always_comb begin
      w_bus_hs                 = obi_req_i && obi_gnt_i;
      w_push_req               = w_bus_hs || pmp_block_i;
      w_push_entry.req_payload = obi_req_payload_i;
      w_push_entry.blocked     = pmp_block_i && !w_bus_hs;
      w_push                   = w_push_req && !w_full;
      w_overflow               = w_push_req && w_full;
      w_pop                    = 1'b0;
      w_protocol               = pmp_block_i && w_bus_hs;
      if (w_empty) begin
         w_protocol = w_protocol || obi_rvalid_i;
      end else if (w_head.blocked) begin
         w_pop      = 1'b1;
         w_protocol = w_protocol || obi_rvalid_i;
      end else begin
         w_pop      = obi_rvalid_i;
      end
   end

   cv32e41s_rvfi_obi_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (rvfi_obi_fifo_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head),
      .o_count (outstanding_o)
   );

   // Registered record output: one-cycle valid pulse per pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_rec   <= '0;
      end else begin
         r_valid <= w_pop;
         if (w_pop) r_rec <= build_record(w_head, obi_resp_payload_i);
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_protocol <= 1'b0;
      end else begin
         if (w_overflow) r_overflow <= 1'b1;
         if (w_protocol) r_protocol <= 1'b1;
      end
   end

   assign rvfi_obi_valid_o = r_valid;
   assign rvfi_obi_o       = r_rec;
   assign overflow_err_o   = r_overflow;
   assign protocol_err_o   = r_protocol;

endmodule

// File: tb/tb_cv32e41s_rvfi_obi_instr_tracker.sv
// Directed self-checking bench for the RVFI OBI instruction tracker (DEPTH=2).
module tb_cv32e41s_rvfi_obi_instr_tracker;
   import cv32e41s_rvfi_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            obi_req_i;
   logic            obi_gnt_i;
   obi_inst_req_t   obi_req_payload_i;
   logic            obi_rvalid_i;
   inst_resp_t      obi_resp_payload_i;
   logic            pmp_block_i;
   logic            rvfi_obi_valid_o;
   rvfi_obi_instr_t rvfi_obi_o;
   logic [1:0]      outstanding_o;
   logic            overflow_err_o;
   logic            protocol_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   cv32e41s_rvfi_obi_instr_tracker #(.DEPTH(2)) dut (
      .clk                (clk),
      .rst                (rst),
      .obi_req_i          (obi_req_i),
      .obi_gnt_i          (obi_gnt_i),
      .obi_req_payload_i  (obi_req_payload_i),
      .obi_rvalid_i       (obi_rvalid_i),
      .obi_resp_payload_i (obi_resp_payload_i),
      .pmp_block_i        (pmp_block_i),
      .rvfi_obi_valid_o   (rvfi_obi_valid_o),
      .rvfi_obi_o         (rvfi_obi_o),
      .outstanding_o      (outstanding_o),
      .overflow_err_o     (overflow_err_o),
      .protocol_err_o     (protocol_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      obi_req_i          = 1'b0;
      obi_gnt_i          = 1'b0;
      obi_req_payload_i  = '0;
      obi_rvalid_i       = 1'b0;
      obi_resp_payload_i = '0;
      pmp_block_i        = 1'b0;
   endtask

   task automatic hs(input logic [31:0] addr);
      obi_req_i              = 1'b1;
      obi_gnt_i              = 1'b1;
      obi_req_payload_i      = '0;
      obi_req_payload_i.addr = addr;
      obi_req_payload_i.prot = 3'b111;
   endtask

   task automatic blk(input logic [31:0] addr);
      pmp_block_i            = 1'b1;
      obi_req_payload_i      = '0;
      obi_req_payload_i.addr = addr;
   endtask

   task automatic rv(input logic [31:0] rdata);
      obi_rvalid_i             = 1'b1;
      obi_resp_payload_i.rdata = rdata;
      obi_resp_payload_i.err   = 1'b0;
   endtask

   task automatic chk_rec(input string tag, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic pmp);
      chk({tag, ".valid"}, 64'(rvfi_obi_valid_o), 64'd1);
      chk({tag, ".addr"},  64'(rvfi_obi_o.req_payload.addr), 64'(addr));
      chk({tag, ".rdata"}, 64'(rvfi_obi_o.resp_payload.rdata), 64'(rdata));
      chk({tag, ".pmp"},   64'(rvfi_obi_o.pmp_err), 64'(pmp));
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst.valid", 64'(rvfi_obi_valid_o), 64'd0);
      chk("rst.rec",   64'(rvfi_obi_o.req_payload.addr), 64'd0);
      chk("rst.out",   64'(outstanding_o), 64'd0);
      chk("rst.ovf",   64'(overflow_err_o), 64'd0);
      chk("rst.prot",  64'(protocol_err_o), 64'd0);

      // single fetch
      hs(32'h80);               tick();
      chk("single.out1", 64'(outstanding_o), 64'd1);
      idle();                   tick();
      chk("single.novalid", 64'(rvfi_obi_valid_o), 64'd0);
      rv(32'h13);               tick();
      chk_rec("single.rec", 32'h80, 32'h13, 1'b0);
      chk("single.out0", 64'(outstanding_o), 64'd0);
      idle();                   tick();
      chk("single.pulse", 64'(rvfi_obi_valid_o), 64'd0);

      // pipelined fetches, back-to-back responses
      hs(32'h100);              tick();
      hs(32'h104);              tick();
      chk("pipe.out2", 64'(outstanding_o), 64'd2);
      idle(); rv(32'hA);        tick();
      chk_rec("pipe.rec0", 32'h100, 32'hA, 1'b0);
      chk("pipe.out1", 64'(outstanding_o), 64'd1);
      rv(32'hB);                tick();
      chk_rec("pipe.rec1", 32'h104, 32'hB, 1'b0);
      chk("pipe.out0", 64'(outstanding_o), 64'd0);
      idle();                   tick();

      // full with simultaneous push and pop
      hs(32'h300);              tick();
      hs(32'h304);              tick();
      chk("full.out2", 64'(outstanding_o), 64'd2);
      hs(32'h108); rv(32'hC);   tick();
      chk("full.ovf", 64'(overflow_err_o), 64'd1);
      chk("full.out1", 64'(outstanding_o), 64'd1);
      chk_rec("full.rec0", 32'h300, 32'hC, 1'b0);
      idle(); rv(32'hD);        tick();
      chk_rec("full.rec1", 32'h304, 32'hD, 1'b0);
      chk("full.dropped", 64'(outstanding_o), 64'd0);
      chk("full.prot", 64'(protocol_err_o), 64'd0);
      idle();                   tick();

      // mixed PMP-blocked fetch
      hs(32'h200);              tick();
      idle(); blk(32'h204);     tick();
      chk("mix.out2", 64'(outstanding_o), 64'd2);
      chk("mix.noauto", 64'(rvfi_obi_valid_o), 64'd0);
      idle(); rv(32'h55);       tick();
      chk_rec("mix.rec0", 32'h200, 32'h55, 1'b0);
      idle();                   tick();
      chk_rec("mix.rec1", 32'h204, 32'h0, 1'b1);
      chk("mix.out0", 64'(outstanding_o), 64'd0);
      chk("mix.prot", 64'(protocol_err_o), 64'd0);
      tick();
      chk("mix.pulse", 64'(rvfi_obi_valid_o), 64'd0);

      // illegal response on empty FIFO
      rv(32'hE);                tick();
      chk("ill.empty.prot",  64'(protocol_err_o), 64'd1);
      chk("ill.empty.valid", 64'(rvfi_obi_valid_o), 64'd0);
      chk("ill.empty.out",   64'(outstanding_o), 64'd0);

      // illegal response with blocked entry at head; entry still retires
      do_reset();
      chk("ill.clr", 64'(protocol_err_o), 64'd0);
      blk(32'h400);             tick();
      chk("ill.blk.out1", 64'(outstanding_o), 64'd1);
      chk("ill.blk.prot0", 64'(protocol_err_o), 64'd0);
      idle(); rv(32'hF);        tick();
      chk("ill.blk.prot", 64'(protocol_err_o), 64'd1);
      chk_rec("ill.blk.rec", 32'h400, 32'h0, 1'b1);
      chk("ill.blk.out0", 64'(outstanding_o), 64'd0);
      idle();                   tick();

      // handshake and PMP block together: bus entry kept
      do_reset();
      hs(32'h500); pmp_block_i = 1'b1; tick();
      chk("dual.prot", 64'(protocol_err_o), 64'd1);
      chk("dual.out1", 64'(outstanding_o), 64'd1);
      idle(); rv(32'h77);       tick();
      chk_rec("dual.rec", 32'h500, 32'h77, 1'b0);
      idle();                   tick();

      // reset with two outstanding
      do_reset();
      hs(32'h600);              tick();
      hs(32'h604);              tick();
      chk("mrst.out2", 64'(outstanding_o), 64'd2);
      idle(); rv(32'h1); rst = 1'b1; tick();
      rst = 1'b0; idle();
      chk("mrst.valid", 64'(rvfi_obi_valid_o), 64'd0);
      chk("mrst.out",   64'(outstanding_o), 64'd0);
      chk("mrst.rec",   64'(rvfi_obi_o.req_payload.addr), 64'd0);
      chk("mrst.ovf",   64'(overflow_err_o), 64'd0);
      chk("mrst.prot",  64'(protocol_err_o), 64'd0);
      rv(32'h2);                tick();
      chk("mrst.late.prot",  64'(protocol_err_o), 64'd1);
      chk("mrst.late.valid", 64'(rvfi_obi_valid_o), 64'd0);
      chk("mrst.late.out",   64'(outstanding_o), 64'd0);
      idle();                   tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
